udp_rx: RTL
===========

# udp_rx

Receive-side UDP/IPv4 parser for the GMII datapath, the counterpart to the UDP transmit path. It consumes raw GMII receive bytes, checks the preamble/SFD, and filters frames on MAC, EtherType, IP header, destination IP and destination port. Accepted payload is delivered as big-endian 16-bit words, and completion is flagged with the payload byte count and the sender's MAC/IP, so the reply path can address its response. The FCS is not checked; it is skipped.

## Interface
Parameters:
- FPGA_MAC, 48'h00_11_22_33_44_55, local MAC; frames to this address or to 48'hFF_FF_FF_FF_FF_FF are accepted
- FPGA_IP, 32'hC0_A8_00_03, local IP (192.168.0.3)
- UDP_PORT, 16'h8000, accepted destination port

Ports:
- gmii_rxc  in  1  receive clock; all logic on rising edge
- rstn  in  1  reset; synchronous, active-low
- gmii_rx_dv  in  1  GMII receive data valid
- gmii_rxd  in  8  GMII receive byte
- udp_rx_data  out  16  payload word, first byte in [15:8]
- udp_rx_data_en  out  1  one-cycle strobe, udp_rx_data valid
- udp_rx_done  out  1  one-cycle strobe, frame payload complete
- udp_rx_byte_num  out  16  payload byte count (UDP length − 8); held until next accepted UDP header
- src_mac  out  48  source MAC of last accepted frame
- src_ip  out  32  source IP of last accepted frame
- udp_rx_err  out  1  one-cycle strobe, gmii_rx_dv dropped before payload end

## Operation
- Reset: every output is 0, state is IDLE, and all counters are 0.
- The FSM is IDLE → PRE_DATA → ETH_HEAD → IP_HEAD → UDP_HEAD → UDP_DATA → WAIT_END → IDLE.
- Only bytes with gmii_rx_dv = 1 are processed.
- IDLE: on dv && rxd == 8'h55, go to PRE_DATA and set the byte counter to 1.
- PRE_DATA:
  - Bytes 1–6 must be 8'h55.
  - Byte 7 must be 8'hD5, after which go to ETH_HEAD.
  - Any mismatch goes to WAIT_END.
- ETH_HEAD (14 bytes):
  - Capture dest MAC, src MAC and EtherType.
  - At byte 13, check that dest is FPGA_MAC or all-ones and EtherType is 16'h0800.
  - Pass goes to IP_HEAD; fail goes to WAIT_END.
- IP_HEAD (20 bytes):
  - Byte 0 must be 8'h45; options are rejected.
  - Byte 9 must be 8'h11.
  - Bytes 12–15 are captured as the source IP.
  - Bytes 16–19 must equal FPGA_IP.
  - The IP checksum is not verified.
  - Pass goes to UDP_HEAD; fail goes to WAIT_END.
- UDP_HEAD (8 bytes):
  - Bytes 2–3 must equal UDP_PORT.
  - Bytes 4–5 give udp_len.
  - udp_len < 9 (zero-length payload) goes to WAIT_END.
  - Otherwise, at byte 7, register payload_len = udp_len − 8 (16-bit arithmetic), load udp_rx_byte_num, src_mac and src_ip, and go to UDP_DATA.
- UDP_DATA:
  - Count payload bytes from 0 to payload_len − 1.
  - Even-index bytes go to data[15:8]; odd-index bytes go to data[7:0] and strobe udp_rx_data_en.
  - If payload_len is odd, the last byte is output with [7:0] = 8'h00 and strobed.
  - After the last payload byte, strobe udp_rx_done and go to WAIT_END.
- WAIT_END: discard bytes (Ethernet pad, FCS, rejected frames) until gmii_rx_dv = 0, then go to IDLE.
- dv drop:
  - gmii_rx_dv = 0 in any state other than IDLE or WAIT_END returns to IDLE immediately.
  - Inside UDP_DATA it also pulses udp_rx_err. No done pulse and no partial-word strobe are issued.
- Reset mid-frame: return to IDLE and clear outputs. The next frame is only recognised after a fresh preamble; a frame already in progress falls into WAIT_END or IDLE naturally.

## Timing
- Registered outputs:
  - udp_rx_data and udp_rx_data_en are asserted on the clock edge after the word's second byte (or the odd last byte) is sampled, i.e. 1-cycle latency.
  - udp_rx_done asserts in the same cycle as the final udp_rx_data_en.
- udp_rx_byte_num, src_mac and src_ip update in the cycle after UDP header byte 7. They are stable for the whole payload and until the next accepted header.
- Minimum spacing between data strobes is 2 cycles. There is no backpressure; the consumer must accept every strobe.
- Back-to-back frames separated by at least 1 dv-low cycle must both be received.

## Test plan
- Valid frame, dest MAC = FPGA_MAC, dest IP = FPGA_IP, port 16'h8000, udp_len = 28, payload 8'h01..8'h14, followed by pad and FCS → 10 strobes 16'h0102 … 16'h1314, done with the last strobe, byte_num = 20, src_mac/src_ip match the header.
- Same frame with dest MAC 48'hFF_FF_FF_FF_FF_FF → accepted identically. Dest MAC 48'h00_11_22_33_44_56, or dest IP 192.168.0.4, or port 16'h8001 → no strobes, no done, FSM back in IDLE after dv falls.
- Odd payload, udp_len = 13, bytes AA BB CC DD EE → words 16'hAABB, 16'hCCDD, 16'hEE00, done with the third strobe, byte_num = 5.
- dv dropped after 3 payload bytes of a 20-byte frame → one strobe (first word), udp_rx_err pulse, no done; the next valid frame is received correctly.
- Bad SFD (8'h55 ×7 then 8'h55), or IP byte 0 = 8'h46 → frame ignored, no outputs.
- rstn low for 1 cycle mid-payload → all outputs 0, idle; a following valid frame is received normally.

Source files
------------

// File: rtl/udp_rx.sv
// udp_rx: GMII receive-side UDP/IPv4 parser.
// Filters on MAC, EtherType, IP and port; emits payload as 16-bit words.
module udp_rx #(
   parameter logic [47:0] FPGA_MAC = 48'h00_11_22_33_44_55,
   parameter logic [31:0] FPGA_IP  = 32'hC0_A8_00_03,
   parameter logic [15:0] UDP_PORT = 16'h8000
) (
   input  logic        gmii_rxc,
   input  logic        rstn,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic [15:0] udp_rx_data,
   output logic        udp_rx_data_en,
   output logic        udp_rx_done,
   output logic [15:0] udp_rx_byte_num,
   output logic [47:0] src_mac,
   output logic [31:0] src_ip,
   output logic        udp_rx_err
);

   typedef enum logic [2:0] {
      IDLE, PRE_DATA, ETH_HEAD, IP_HEAD,
      UDP_HEAD, UDP_DATA, WAIT_END
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt;
   logic [7:0]  hi_byte;
   logic [7:0]  data_hi;
   logic [47:0] dst_mac;
   logic [47:0] mac_tmp;
   logic [31:0] ip_tmp;
   logic [15:0] udp_len;
   logic [15:0] payload_len;
   logic [7:0]  ip_byte;
   logic        mac_ok;
   logic        last;

   assign mac_ok = (dst_mac == FPGA_MAC) || (&dst_mac);
   assign last   = (cnt == payload_len - 16'd1);

   always_comb begin
      ip_byte = FPGA_IP[7:0];
      case (cnt[1:0])
         2'd0:    ip_byte = FPGA_IP[31:24];
         2'd1:    ip_byte = FPGA_IP[23:16];
         2'd2:    ip_byte = FPGA_IP[15:8];
         default: ip_byte = FPGA_IP[7:0];
      endcase
   end

   always_ff @(posedge gmii_rxc) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // dv low always returns to IDLE; WAIT_END only leaves that way
   always_comb begin
      state_nxt = state;
      if (!gmii_rx_dv) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:
               if (gmii_rxd == 8'h55) state_nxt = PRE_DATA;
            PRE_DATA:
               if (cnt == 16'd7)
                  state_nxt = (gmii_rxd == 8'hD5) ? ETH_HEAD : WAIT_END;
               else if (gmii_rxd != 8'h55)
                  state_nxt = WAIT_END;
            ETH_HEAD:
               if (cnt == 16'd13)
                  state_nxt = (mac_ok && {hi_byte, gmii_rxd} == 16'h0800)
                              ? IP_HEAD : WAIT_END;
            IP_HEAD:
               if (cnt == 16'd0 && gmii_rxd != 8'h45)
                  state_nxt = WAIT_END;
               else if (cnt == 16'd9 && gmii_rxd != 8'h11)
                  state_nxt = WAIT_END;
               else if (cnt >= 16'd16 && gmii_rxd != ip_byte)
                  state_nxt = WAIT_END;
               else if (cnt == 16'd19)
                  state_nxt = UDP_HEAD;
            UDP_HEAD:
               if (cnt == 16'd3 && {hi_byte, gmii_rxd} != UDP_PORT)
                  state_nxt = WAIT_END;
               else if (cnt == 16'd5 && {udp_len[7:0], gmii_rxd} < 16'd9)
                  state_nxt = WAIT_END;
               else if (cnt == 16'd7)
                  state_nxt = UDP_DATA;
            UDP_DATA:
               if (last) state_nxt = WAIT_END;
            WAIT_END:
               state_nxt = WAIT_END;
            default:
               state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge gmii_rxc) begin
      if (!rstn) begin
         cnt             <= '0;
         hi_byte         <= '0;
         data_hi         <= '0;
         dst_mac         <= '0;
         mac_tmp         <= '0;
         ip_tmp          <= '0;
         udp_len         <= '0;
         payload_len     <= '0;
         udp_rx_data     <= '0;
         udp_rx_data_en  <= 1'b0;
         udp_rx_done     <= 1'b0;
         udp_rx_byte_num <= '0;
         src_mac         <= '0;
         src_ip          <= '0;
         udp_rx_err      <= 1'b0;
      end else begin
         udp_rx_data_en <= 1'b0;
         udp_rx_done    <= 1'b0;
         udp_rx_err     <= (state == UDP_DATA) && !gmii_rx_dv;
         if (state_nxt != state)
            cnt <= (state_nxt == PRE_DATA) ? 16'd1 : 16'd0;
         else if (state != IDLE && state != WAIT_END)
            cnt <= cnt + 16'd1;
         if (gmii_rx_dv) begin
            unique case (state)
               ETH_HEAD:
                  if (cnt < 16'd6)
                     dst_mac <= {dst_mac[39:0], gmii_rxd};
                  else if (cnt < 16'd12)
                     mac_tmp <= {mac_tmp[39:0], gmii_rxd};
                  else if (cnt == 16'd12)
                     hi_byte <= gmii_rxd;
               IP_HEAD:
                  if (cnt >= 16'd12 && cnt < 16'd16)
                     ip_tmp <= {ip_tmp[23:0], gmii_rxd};
               UDP_HEAD: begin
                  if (cnt == 16'd2)
                     hi_byte <= gmii_rxd;
                  if (cnt == 16'd4 || cnt == 16'd5)
                     udp_len <= {udp_len[7:0], gmii_rxd};
                  if (cnt == 16'd7) begin
                     payload_len     <= udp_len - 16'd8;
                     udp_rx_byte_num <= udp_len - 16'd8;
                     src_mac         <= mac_tmp;
                     src_ip          <= ip_tmp;
                  end
               end
               UDP_DATA:
                  if (!cnt[0]) begin
                     data_hi <= gmii_rxd;
                     if (last) begin
                        udp_rx_data    <= {gmii_rxd, 8'h00};
                        udp_rx_data_en <= 1'b1;
                        udp_rx_done    <= 1'b1;
                     end
                  end else begin
                     udp_rx_data    <= {data_hi, gmii_rxd};
                     udp_rx_data_en <= 1'b1;
                     udp_rx_done    <= last;
                  end
               default: ;
            endcase
         end
      end
   end

endmodule
